cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
- Shares the single cache-bus (CBus) master port between NUM_REQ requesters, typically instruction fetch and data memory of the core.
- Its output feeds the CBus-to-AXI converter.
- Selects one pending request, forwards it unchanged until the final response beat, then re-arbitrates round-robin.
- Routes the response to the granted requester only; all other requesters see an idle response.

Parameters:
- NUM_REQ, 2, number of requesters (index 0 = instruction fetch, 1 = data); legal range 2..8.
- IDX_W, $clog2(NUM_REQ), width of the grant index; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ireqs  in  NUM_REQ x 77  per-requester cbus_req_t: valid[1], is_write[1], size[3], addr[32], strobe[4], data[32], len[4].
- iresps  out  NUM_REQ x 34  per-requester cbus_resp_t: ready[1], last[1], data[32].
- oreq  out  77  cbus_req_t to the converter.
- oresp  in  34  cbus_resp_t from the converter.
- busy  out  1  high while a transaction is granted.
- grant_idx  out  IDX_W  index of the current or most recent grant.

Behaviour:
- Two-state FSM: IDLE, BUSY. Registers: state, sel (IDX_W), last_grant (IDX_W).
- Reset (asynchronous assert, any state):
  - state=IDLE, sel=0, last_grant=NUM_REQ-1, so requester 0 wins first.
  - Outputs during and after reset: oreq all-zero (valid=0), every iresps all-zero, busy=0, grant_idx=0.
- IDLE:
  - oreq=0 and all iresps=0.
  - If any ireqs[i].valid: choose the first valid index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Next edge: sel=that index, state=BUSY.
  - No valid request: remain IDLE.
- BUSY:
  - oreq = ireqs[sel], forwarded combinationally, all fields including valid.
  - iresps[sel] = oresp; iresps[j] = 0 for j != sel.
  - On an edge where oresp.ready && oresp.last: state=IDLE, last_grant=sel.
  - oresp.ready without last: intermediate beat of a burst (len+1 beats total); remain BUSY.
- Latency:
  - Request asserted in cycle t while IDLE → oreq.valid in cycle t+1.
  - Final beat accepted in cycle t → IDLE in t+1 (one bubble cycle) → next grant's oreq.valid in t+2.
- Requester protocol: hold valid and all fields stable from assertion until the cycle its iresps shows ready&&last. The arbiter does not re-latch request fields.
- Boundaries:
  - A requester dropping valid mid-grant is a protocol violation; the arbiter stays BUSY until oresp last. The bench asserts this never happens.
  - A request arriving in the same cycle a grant completes is seen in IDLE the next cycle; there is no same-cycle re-grant.
  - last_grant wraps NUM_REQ-1 → 0.
  - oresp.ready in IDLE is ignored.
  - Reset asserted mid-burst aborts the grant immediately. The converter is reset by the same signal.
  - busy = (state==BUSY); grant_idx = sel.
- Width rules: round-robin modulo uses IDX_W arithmetic with explicit wrap when NUM_REQ is not a power of two.

Decomposition:
- cbus_req_t and cbus_resp_t belong in the shared common package already used by the converter and core; the arbiter imports them.
- Enum arb_state_t {IDLE, BUSY} is local to the module.
- One sub-module is natural: rr_pick.
  - Combinational; inputs valid vector and last_grant; outputs found and index.
  - Reusable by a future multi-master uncached arbiter.

Test Plan:
- Single read: only ireqs[0].valid, addr=0xBFC0_0000, len=0; converter returns ready=1,last=1,data=0x2408_0001 in the 2nd BUSY cycle → iresps[0].data=0x2408_0001, iresps[1] all-zero, IDLE afterward, last_grant=0.
- Simultaneous after reset: both valid in cycle 1 → grant_idx=0 in cycle 2; after its last beat, grant_idx=1 two cycles later.
- Round-robin fairness: both continuously valid, len=0, slave answers after 1 cycle → grants alternate 0,1,0,1 for 8 transactions; never two consecutive grants to one index.
- Burst: ireqs[1] write len=3 to 0x8000_0100, strobe=0xF; four ready beats with last on the 4th → stays BUSY through beats 1-3, IDLE the cycle after beat 4; ireqs[0] valid meanwhile gets no ready.
- Reset mid-burst: reset high during beat 2 of a len=3 read → oreq.valid=0 and all iresps zero in the same cycle; after release, requester 0 wins first.
- NUM_REQ=3 wrap: last_grant=2, requesters 0 and 2 valid → grant 0; then requesters 1 and 2 valid → grant 1.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus request/response types used by the core, the arbiter and the
// CBus-to-AXI converter.
package cbus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    // A response beat that closes the current transaction.
    function automatic logic resp_final(input cbus_resp_t resp);
        return resp.ready && resp.last;
    endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bus bundle between NUM_REQ cache-bus requesters, the arbiter and the converter.
interface cbus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import cbus_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    cbus_req_t              ireqs  [NUM_REQ];
    cbus_resp_t             iresps [NUM_REQ];
    cbus_req_t              oreq;
    cbus_resp_t             oresp;
    logic                   busy;
    logic [IDX_W-1:0]       grant_idx;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output busy,
        output grant_idx
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  busy,
        input  grant_idx
    );

endinterface

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after i_last_grant,
// wrapping at NUM_REQ-1 so non-power-of-two requester counts work.
module cbus_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = i_last_grant;
        // The last candidate visited is last_grant itself, so a lone requester re-wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + IDX_W'(1);
            if (!o_found && i_valid[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Shares the single CBus master port between NUM_REQ requesters; holds a grant until
// the final response beat, then re-arbitrates round-robin after one idle cycle.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic          clk,
    input  logic          reset,
    cbus_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   w_sel_next;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_last_grant_next;
    logic [NUM_REQ-1:0] w_valid;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_busy;
    logic               w_final;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_valid
            assign w_valid[gi] = bus.ireqs[gi].valid;
        end
    endgenerate

    cbus_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_found      (w_found),
        .o_idx        (w_pick)
    );

    // last_grant resets to the top index so requester 0 is the first winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_next;
            r_sel        <= w_sel_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_sel_next        = r_sel;
        w_last_grant_next = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = BUSY;
                    w_sel_next   = w_pick;
                end
            end
            BUSY: begin
                if (w_final) begin
                    w_state_next      = IDLE;
                    w_last_grant_next = r_sel;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_busy  = (r_state == BUSY);
    assign w_final = resp_final(bus.oresp);

    // The granted request is forwarded as-is; the requester keeps it stable until done.
    assign bus.oreq      = w_busy ? bus.ireqs[r_sel] : '0;
    assign bus.busy      = w_busy;
    assign bus.grant_idx = r_sel;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp
            assign bus.iresps[gi] = (w_busy && (r_sel == IDX_W'(gi))) ? bus.oresp : '0;
        end
    endgenerate

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: a 2-requester and a 3-requester instance run directed and
// random traffic against a queue-free round-robin ownership model.
`timescale 1ns/1ps
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cbus_arbiter_if #(.NUM_REQ(2)) bus2 ();
    cbus_arbiter_if #(.NUM_REQ(3)) bus3 ();

    cbus_arbiter #(.NUM_REQ(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
    cbus_arbiter #(.NUM_REQ(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    cbus_req_t  req_d  [2][8];
    cbus_resp_t resp_d [2];
    cbus_req_t  oreq_o [2];
    cbus_resp_t ires_o [2][8];
    logic       busy_o [2];
    logic [2:0] gidx_o [2];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_map
            if (gi < 2) begin : g_d2
                assign bus2.ireqs[gi]  = req_d[0][gi];
                assign ires_o[0][gi]   = bus2.iresps[gi];
            end else begin : g_d2z
                assign ires_o[0][gi]   = '0;
            end
            if (gi < 3) begin : g_d3
                assign bus3.ireqs[gi]  = req_d[1][gi];
                assign ires_o[1][gi]   = bus3.iresps[gi];
            end else begin : g_d3z
                assign ires_o[1][gi]   = '0;
            end
        end
    endgenerate

    assign bus2.oresp = resp_d[0];
    assign bus3.oresp = resp_d[1];
    assign oreq_o[0]  = bus2.oreq;
    assign oreq_o[1]  = bus3.oreq;
    assign busy_o[0]  = bus2.busy;
    assign busy_o[1]  = bus3.busy;
    assign gidx_o[0]  = {2'b00, bus2.grant_idx};
    assign gidx_o[1]  = {1'b0, bus3.grant_idx};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: who owns the bus (-1 = nobody), who owned it last, beats accepted.
    int m_owner [2];
    int m_last  [2];
    int m_gidx  [2];
    int m_beat  [2];
    bit fin     [2][8];
    bit pend    [2][8];

    function automatic int nreq(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int pick(input int d);
        for (int k = 1; k <= nreq(d); k++) begin
            int c;
            c = (m_last[d] + k) % nreq(d);
            if (req_d[d][c].valid) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int d, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s dut%0d @%0t: got %h want %h", nm, d, $time, got, exp);
        end
    endtask

    initial begin : model
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_last[d] = nreq(d) - 1; m_gidx[d] = 0; m_beat[d] = 0;
        end
        forever begin
            @(posedge clk or posedge reset);
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    m_owner[d] = -1; m_last[d] = nreq(d) - 1; m_gidx[d] = 0; m_beat[d] = 0;
                end else if (m_owner[d] < 0) begin
                    m_owner[d] = pick(d);
                    if (m_owner[d] >= 0) begin
                        m_gidx[d] = m_owner[d];
                        m_beat[d] = 0;
                    end
                end else if (resp_d[d].ready) begin
                    if (resp_d[d].last) begin
                        fin[d][m_owner[d]] = 1'b1;
                        m_last[d]  = m_owner[d];
                        m_owner[d] = -1;
                    end else begin
                        m_beat[d]++;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                cbus_req_t  e_req;
                cbus_resp_t e_resp;
                e_req = '0;
                if (m_owner[d] >= 0) e_req = req_d[d][m_owner[d]];
                chk("oreq", d, 80'(oreq_o[d]), 80'(e_req));
                for (int i = 0; i < nreq(d); i++) begin
                    e_resp = (m_owner[d] == i) ? resp_d[d] : '0;
                    chk($sformatf("iresps%0d", i), d, 80'(ires_o[d][i]), 80'(e_resp));
                end
                chk("busy", d, 80'(busy_o[d]), 80'(m_owner[d] >= 0));
                chk("grant_idx", d, 80'(gidx_o[d]), 80'(m_gidx[d]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t mkreq(input logic w, input logic [31:0] a, input logic [3:0] l);
        cbus_req_t r;
        r.valid = 1'b1; r.is_write = w; r.size = 3'd2; r.addr = a;
        r.strobe = w ? 4'hF : 4'h0; r.data = $urandom; r.len = l;
        return r;
    endfunction

    function automatic cbus_req_t rndreq(input logic v);
        cbus_req_t r;
        r.valid = v; r.is_write = 1'($urandom_range(0, 1)); r.size = 3'($urandom_range(0, 2));
        r.addr = $urandom; r.strobe = 4'($urandom); r.data = $urandom;
        r.len = 4'($urandom_range(0, 3));
        return r;
    endfunction

    function automatic cbus_resp_t mkresp(input logic rdy, input logic lst, input logic [31:0] dt);
        cbus_resp_t r;
        r.ready = rdy; r.last = lst; r.data = dt;
        return r;
    endfunction

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            resp_d[d] = '0;
            for (int i = 0; i < 8; i++) begin
                req_d[d][i] = '0; fin[d][i] = 1'b0; pend[d][i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin : stim
        clear_inputs();
        step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_oreq", d, 80'(oreq_o[d]), 80'h0);
            chk("rst_busy", d, 80'(busy_o[d]), 80'h0);
            chk("rst_gidx", d, 80'(gidx_o[d]), 80'h0);
        end
        step();
        reset = 1'b0;

        // Single read from instruction fetch
        req_d[0][0] = mkreq(1'b0, 32'hBFC0_0000, 4'd0);
        #1 chk("a_idle_valid", 0, 80'(oreq_o[0].valid), 80'h0);
        step();
        chk("a_busy", 0, 80'(busy_o[0]), 80'h1);
        chk("a_addr", 0, 80'(oreq_o[0].addr), 80'hBFC0_0000);
        step();
        resp_d[0] = mkresp(1'b1, 1'b1, 32'h2408_0001);
        #1 chk("a_data0", 0, 80'(ires_o[0][0].data), 80'h2408_0001);
        chk("a_resp1", 0, 80'(ires_o[0][1]), 80'h0);
        step();
        req_d[0][0] = '0; resp_d[0] = '0;
        #1 chk("a_idle", 0, 80'(busy_o[0]), 80'h0);

        // Simultaneous requests after reset
        do_reset();
        req_d[0][0] = mkreq(1'b0, 32'h0000_1000, 4'd0);
        req_d[0][1] = mkreq(1'b1, 32'h0000_2000, 4'd0);
        step();
        chk("b_first", 0, 80'(gidx_o[0]), 80'h0);
        resp_d[0] = mkresp(1'b1, 1'b1, 32'h1111_0000);
        step();
        req_d[0][0] = '0; resp_d[0] = '0;
        step();
        chk("b_second", 0, 80'(gidx_o[0]), 80'h1);
        resp_d[0] = mkresp(1'b1, 1'b1, 32'h2222_0000);
        step();
        req_d[0][1] = '0; resp_d[0] = '0;

        // Round-robin fairness with both requesters always valid
        req_d[0][0] = mkreq(1'b0, 32'h1000_0000, 4'd0);
        req_d[0][1] = mkreq(1'b0, 32'h2000_0000, 4'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("c_rr_grant", 0, 80'(gidx_o[0]), 80'(k % 2));
            step();
            resp_d[0] = mkresp(1'b1, 1'b1, $urandom);
            step();
            resp_d[0] = '0;
            req_d[0][k % 2] = mkreq(1'b0, 32'h3000_0000 + 32'(k * 4), 4'd0);
        end
        req_d[0][0] = '0; req_d[0][1] = '0;

        // Four-beat write burst from the data side, fetch waiting
        req_d[0][1] = mkreq(1'b1, 32'h8000_0100, 4'd3);
        step();
        chk("d_grant", 0, 80'(gidx_o[0]), 80'h1);
        req_d[0][0] = mkreq(1'b0, 32'h0000_4000, 4'd0);
        for (int b = 0; b < 4; b++) begin
            step();
            resp_d[0] = mkresp(1'b1, b == 3, $urandom);
            #1 chk("d_busy", 0, 80'(busy_o[0]), 80'h1);
            chk("d_ires0_ready", 0, 80'(ires_o[0][0].ready), 80'h0);
            chk("d_ires1_ready", 0, 80'(ires_o[0][1].ready), 80'h1);
        end
        step();
        resp_d[0] = '0; req_d[0][1] = '0;
        #1 chk("d_idle", 0, 80'(busy_o[0]), 80'h0);
        step();
        chk("d_next", 0, 80'(gidx_o[0]), 80'h0);
        resp_d[0] = mkresp(1'b1, 1'b1, 32'h5);
        step();
        resp_d[0] = '0; req_d[0][0] = '0;

        // Reset during the second beat of a burst
        req_d[0][1] = mkreq(1'b0, 32'h9000_0000, 4'd3);
        step();
        chk("e_grant", 0, 80'(gidx_o[0]), 80'h1);
        resp_d[0] = mkresp(1'b1, 1'b0, 32'h6);
        step();
        resp_d[0] = mkresp(1'b1, 1'b0, 32'h7);
        #1 reset = 1'b1;
        #1 chk("e_valid", 0, 80'(oreq_o[0].valid), 80'h0);
        chk("e_ires0", 0, 80'(ires_o[0][0]), 80'h0);
        chk("e_ires1", 0, 80'(ires_o[0][1]), 80'h0);
        chk("e_busy", 0, 80'(busy_o[0]), 80'h0);
        step();
        reset = 1'b0; resp_d[0] = '0;
        req_d[0][0] = mkreq(1'b0, 32'hA000_0000, 4'd0);
        req_d[0][1] = mkreq(1'b0, 32'hB000_0000, 4'd0);
        step();
        chk("e_first", 0, 80'(gidx_o[0]), 80'h0);
        resp_d[0] = mkresp(1'b1, 1'b1, 32'h8);
        step();
        clear_inputs();

        // Three requesters: wrap from last_grant=2
        req_d[1][0] = mkreq(1'b0, 32'hC000_0000, 4'd0);
        req_d[1][2] = mkreq(1'b0, 32'hC000_0008, 4'd0);
        step();
        chk("f_grant0", 1, 80'(gidx_o[1]), 80'h0);
        resp_d[1] = mkresp(1'b1, 1'b1, 32'h9);
        step();
        resp_d[1] = '0; req_d[1][0] = '0;
        req_d[1][1] = mkreq(1'b0, 32'hC000_0004, 4'd0);
        step();
        chk("f_grant1", 1, 80'(gidx_o[1]), 80'h1);
        resp_d[1] = mkresp(1'b1, 1'b1, 32'hA);
        step();
        resp_d[1] = '0; req_d[1][1] = '0;
        step();
        chk("f_grant2", 1, 80'(gidx_o[1]), 80'h2);
        resp_d[1] = mkresp(1'b1, 1'b1, 32'hB);
        step();
        clear_inputs();

        // Random traffic on both instances with occasional resets
        do_reset();
        clear_inputs();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            if (reset) reset = 1'b0;
            for (int d = 0; d < 2; d++) begin
                logic rdy;
                for (int i = 0; i < nreq(d); i++) begin
                    if (fin[d][i]) begin
                        fin[d][i]  = 1'b0;
                        pend[d][i] = 1'b0;
                    end
                    if (!pend[d][i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            pend[d][i]  = 1'b1;
                            req_d[d][i] = rndreq(1'b1);
                        end else begin
                            req_d[d][i] = rndreq(1'b0);
                        end
                    end
                end
                rdy = ($urandom_range(0, 2) != 0);
                if (m_owner[d] >= 0)
                    resp_d[d] = mkresp(rdy, rdy && (m_beat[d] == int'(req_d[d][m_owner[d]].len)), $urandom);
                else
                    resp_d[d] = mkresp(rdy, 1'($urandom_range(0, 1)), $urandom);
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                for (int d = 0; d < 2; d++)
                    for (int i = 0; i < 8; i++) begin
                        pend[d][i] = 1'b0; fin[d][i] = 1'b0;
                    end
            end
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
